// File: rtl/sopc_mem_ctrl.sv
// Unified single-port word RAM shared by the fetch port and the load/store port.
// One access at a time, optional wait states, alternating grant under contention.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no access in flight; grant a requesting port
// S_BUSY | access latched; counting wait states, access on cnt == 0
// S_RESP | completion cycle; ready pulse to the granted port
module sopc_mem_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_inst_o,
   output logic        if_ready_o,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        mem_ready_o,
   output logic        stall_req_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    gnt_if_q;
   logic                    last_if_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic                    we_q;
   logic [3:0]              sel_q;
   logic [31:0]             wdata_q;
   logic [31:0]             ram [DEPTH];

   logic                    grant_if;
   logic                    gnt_ce;
   logic                    grab;
   logic                    access;

   // Byte-offset bits and bits above the word index are intentionally dropped.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^{if_addr_i, mem_addr_i};

   // MEM wins unless both request and MEM had the previous grant.
   assign grant_if = if_ce_i & (~mem_ce_i | ~last_if_q);
   assign gnt_ce   = gnt_if_q ? if_ce_i : mem_ce_i;

   // Next-state logic: grant, wait-state countdown, abort on dropped request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grab    = 1'b0;
      access  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (if_ce_i || mem_ce_i) begin
               grab    = 1'b1;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!gnt_ce) begin
               state_d = S_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access  = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, request latches and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         gnt_if_q   <= 1'b0;
         last_if_q  <= 1'b1;
         idx_q      <= '0;
         we_q       <= 1'b0;
         sel_q      <= 4'd0;
         wdata_q    <= 32'd0;
         if_inst_o  <= 32'd0;
         mem_data_o <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grab) begin
            gnt_if_q  <= grant_if;
            last_if_q <= grant_if;
            idx_q     <= grant_if ? if_addr_i[ADDR_WIDTH+1:2] : mem_addr_i[ADDR_WIDTH+1:2];
            we_q      <= ~grant_if & mem_we_i;
            sel_q     <= mem_sel_i;
            wdata_q   <= mem_data_i;
         end
         if (access && !we_q) begin
            if (gnt_if_q) if_inst_o  <= ram[idx_q];
            else          mem_data_o <= ram[idx_q];
         end
      end
   end

   // RAM write on the single BUSY->RESP edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (access && we_q) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign if_ready_o  = (state_q == S_RESP) &  gnt_if_q;
   assign mem_ready_o = (state_q == S_RESP) & ~gnt_if_q;
   assign stall_req_o = (if_ce_i | mem_ce_i) & ~(if_ready_o | mem_ready_o);

endmodule

// File: tb/tb_sopc_mem_ctrl.sv
// Bench for sopc_mem_ctrl: two instances (small/no-wait and default/3-wait),
// directed scenarios followed by randomized traffic against a word-array model.
module tb_sopc_mem_ctrl;

   localparam int AW0 = 4;
   localparam int WC0 = 0;
   localparam int AW1 = 10;
   localparam int WC1 = 3;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        if_ce     [2];
   logic [31:0] if_addr   [2];
   logic [31:0] if_inst   [2];
   logic        if_ready  [2];
   logic        mem_ce    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [3:0]  mem_sel   [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        mem_ready [2];
   logic        stall     [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [2][1024];
   bit          last_mem [2];
   logic [31:0] exp_mem_out [2];
   logic [31:0] exp_if_out  [2];

   always #5 clk = ~clk;

   sopc_mem_ctrl #(.ADDR_WIDTH(AW0), .WAIT_CYCLES(WC0)) dut0 (
      .clk(clk), .rst(rst[0]),
      .if_ce_i(if_ce[0]), .if_addr_i(if_addr[0]), .if_inst_o(if_inst[0]), .if_ready_o(if_ready[0]),
      .mem_ce_i(mem_ce[0]), .mem_we_i(mem_we[0]), .mem_addr_i(mem_addr[0]), .mem_sel_i(mem_sel[0]),
      .mem_data_i(mem_wdata[0]), .mem_data_o(mem_rdata[0]), .mem_ready_o(mem_ready[0]),
      .stall_req_o(stall[0]));

   sopc_mem_ctrl #(.ADDR_WIDTH(AW1), .WAIT_CYCLES(WC1)) dut1 (
      .clk(clk), .rst(rst[1]),
      .if_ce_i(if_ce[1]), .if_addr_i(if_addr[1]), .if_inst_o(if_inst[1]), .if_ready_o(if_ready[1]),
      .mem_ce_i(mem_ce[1]), .mem_we_i(mem_we[1]), .mem_addr_i(mem_addr[1]), .mem_sel_i(mem_sel[1]),
      .mem_data_i(mem_wdata[1]), .mem_data_o(mem_rdata[1]), .mem_ready_o(mem_ready[1]),
      .stall_req_o(stall[1]));

   function automatic int aw(input int k);
      return (k == 0) ? AW0 : AW1;
   endfunction

   function automatic int wc(input int k);
      return (k == 0) ? WC0 : WC1;
   endfunction

   function automatic int widx(input int k, input logic [31:0] a);
      logic [31:0] m;
      m = (32'd1 << aw(k)) - 32'd1;
      return int'((a >> 2) & m);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] m;
      m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      return (old & ~m) | (d & m);
   endfunction

   function automatic logic [31:0] raddr(input int k, input int idx);
      logic [31:0] m;
      m = ((32'd1 << aw(k)) - 32'd1) << 2;
      return ($urandom() & ~m) | (32'(idx) << 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] rdy(input int k);
      return 32'({if_ready[k], mem_ready[k]});
   endfunction

   task automatic set_mem(input int k, input logic we, input logic [31:0] a,
                          input logic [3:0] sel, input logic [31:0] d);
      mem_we[k] = we; mem_addr[k] = a; mem_sel[k] = sel; mem_wdata[k] = d;
   endtask

   task automatic chk_zero(input int k);
      chk("rst_if_inst", if_inst[k], 32'd0);
      chk("rst_mem_data", mem_rdata[k], 32'd0);
      chk("rst_ready", rdy(k), 32'd0);
      chk("rst_stall", 32'(stall[k]), 32'd0);
   endtask

   // Runs one or two simultaneous requests to completion and checks timing/data.
   task automatic xact(input int k, input bit do_if, input bit do_mem);
      bit first_mem, pm;
      int lat, nsv, wi;
      if_ce[k] = do_if; mem_ce[k] = do_mem;
      first_mem = (do_if && do_mem) ? !last_mem[k] : do_mem;
      nsv = (do_if && do_mem) ? 2 : 1;
      for (int s = 0; s < nsv; s++) begin
         pm  = (s == 0) ? first_mem : !first_mem;
         lat = (s == 0) ? wc(k) + 2 : wc(k) + 3;
         for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            chk("wait_ready", rdy(k), 32'd0);
            chk("wait_stall", 32'(stall[k]), 32'd1);
         end
         @(negedge clk);
         chk("ready", rdy(k), pm ? 32'd1 : 32'd2);
         chk("resp_stall", 32'(stall[k]), 32'd0);
         if (pm) begin
            wi = widx(k, mem_addr[k]);
            if (mem_we[k]) mdl[k][wi] = merge(mdl[k][wi], mem_wdata[k], mem_sel[k]);
            else begin
               exp_mem_out[k] = mdl[k][wi];
               chk("load_data", mem_rdata[k], exp_mem_out[k]);
            end
            mem_ce[k] = 1'b0;
         end else begin
            wi = widx(k, if_addr[k]);
            exp_if_out[k] = mdl[k][wi];
            chk("fetch_data", if_inst[k], exp_if_out[k]);
            if_ce[k] = 1'b0;
         end
         last_mem[k] = pm;
      end
      @(negedge clk);
      chk("idle_ready", rdy(k), 32'd0);
      chk("hold_mem", mem_rdata[k], exp_mem_out[k]);
      chk("hold_if", if_inst[k], exp_if_out[k]);
   endtask

   task automatic st(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
      set_mem(k, 1'b1, a, sel, d);
      xact(k, 1'b0, 1'b1);
   endtask

   task automatic ld(input int k, input logic [31:0] a);
      set_mem(k, 1'b0, a, 4'hF, 32'd0);
      xact(k, 1'b0, 1'b1);
   endtask

   task automatic fe(input int k, input logic [31:0] a);
      if_addr[k] = a;
      xact(k, 1'b1, 1'b0);
   endtask

   // Requester drops mem_ce after d cycles while the access is still waiting.
   task automatic abort_mem(input int k, input int d);
      mem_ce[k] = 1'b1;
      for (int c = 1; c <= d; c++) begin
         @(negedge clk);
         chk("abort_wait_ready", rdy(k), 32'd0);
         chk("abort_wait_stall", 32'(stall[k]), 32'd1);
      end
      mem_ce[k] = 1'b0;
      last_mem[k] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("abort_ready", rdy(k), 32'd0);
         chk("abort_stall", 32'(stall[k]), 32'd0);
      end
   endtask

   task automatic rst_dut(input int k);
      if_ce[k] = 1'b0; mem_ce[k] = 1'b0;
      rst[k] = 1'b1;
      #1;
      chk_zero(k);
      @(negedge clk);
      rst[k] = 1'b0;
      last_mem[k] = 1'b0;
      exp_mem_out[k] = 32'd0;
      exp_if_out[k] = 32'd0;
   endtask

   initial begin
      int er, tend, r, d;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; if_ce[k] = 1'b0; if_addr[k] = 32'd0;
         mem_ce[k] = 1'b0; set_mem(k, 1'b0, 32'd0, 4'd0, 32'd0);
         last_mem[k] = 1'b0; exp_mem_out[k] = 32'd0; exp_if_out[k] = 32'd0;
      end
      repeat (2) @(negedge clk);
      chk_zero(0);
      chk_zero(1);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);

      // Basic store/load, no wait states.
      st(0, 32'h10, 32'hDEADBEEF, 4'hF);
      ld(0, 32'h10);
      chk("basic_load", mem_rdata[0], 32'hDEADBEEF);

      // Byte lanes.
      st(0, 32'h20, 32'h11223344, 4'hF);
      st(0, 32'h20, 32'hAABBCCDD, 4'b0100);
      ld(0, 32'h20);
      chk("lane_load", mem_rdata[0], 32'h11BB3344);
      st(0, 32'h20, 32'h55667788, 4'b0000);
      ld(0, 32'h20);
      chk("sel0_load", mem_rdata[0], 32'h11BB3344);

      // Address wrap and abort on the 16-word instance.
      st(0, 32'h40, 32'h5, 4'hF);
      ld(0, 32'h0);
      chk("wrap_load", mem_rdata[0], 32'h5);
      st(0, 32'h8, 32'h77, 4'hF);
      set_mem(0, 1'b1, 32'h8, 4'hF, 32'h9);
      abort_mem(0, 1);
      ld(0, 32'h8);
      chk("abort_keep", mem_rdata[0], 32'h77);

      // Wait states: fetch latency on the 3-wait instance.
      st(1, 32'h0, 32'h12345678, 4'hF);
      fe(1, 32'h0);
      chk("fetch_word", if_inst[1], 32'h12345678);

      // Arbitration with both requests held continuously from reset.
      st(1, 32'h100, 32'hA1A2A3A4, 4'hF);
      st(1, 32'h204, 32'hB1B2B3B4, 4'hF);
      rst_dut(1);
      set_mem(1, 1'b0, 32'h100, 4'hF, 32'd0);
      if_addr[1] = 32'h204;
      if_ce[1] = 1'b1; mem_ce[1] = 1'b1;
      tend = WC1 + 2 + 3 * (WC1 + 3);
      for (int t = 1; t <= tend; t++) begin
         @(negedge clk);
         er = 0;
         for (int j = 0; j < 4; j++)
            if (t == WC1 + 2 + j * (WC1 + 3)) er = (j % 2 == 0) ? 1 : 2;
         chk("arb_ready", rdy(1), 32'(er));
         if (er == 1) chk("arb_load", mem_rdata[1], 32'hA1A2A3A4);
         if (er == 2) chk("arb_fetch", if_inst[1], 32'hB1B2B3B4);
      end
      if_ce[1] = 1'b0; mem_ce[1] = 1'b0;
      last_mem[1] = 1'b0;
      exp_mem_out[1] = 32'hA1A2A3A4;
      exp_if_out[1] = 32'hB1B2B3B4;
      @(negedge clk);
      chk("arb_idle", rdy(1), 32'd0);

      // Reset in the middle of a store.
      st(1, 32'h30, 32'hCAFEF00D, 4'hF);
      ld(1, 32'h30);
      set_mem(1, 1'b1, 32'h30, 4'hF, 32'h0BADC0DE);
      mem_ce[1] = 1'b1;
      repeat (2) @(negedge clk);
      rst_dut(1);
      ld(1, 32'h30);
      chk("rst_keep", mem_rdata[1], 32'hCAFEF00D);

      // Randomized traffic over 16 words per instance.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) st(k, raddr(k, i), $urandom(), 4'hF);
         for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 7));
            set_mem(k, 1'($urandom_range(0, 1)), raddr(k, int'($urandom_range(0, 15))),
                    4'($urandom_range(0, 15)), $urandom());
            if_addr[k] = raddr(k, int'($urandom_range(0, 15)));
            if (r == 0) begin
               d = int'($urandom_range(1, wc(k) + 1));
               abort_mem(k, d);
            end else if (r <= 2) xact(k, 1'b1, 1'b0);
            else if (r <= 5) xact(k, 1'b0, 1'b1);
            else xact(k, 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sopc_mem_ctrl.md
# sopc_mem_ctrl

Parametrised unified memory controller for the minimal SOPC, the successor to the fixed combinational ROM/RAM pair. One single-port word RAM serves both the instruction-fetch port and the load/store port. Access latency is configurable through wait states, and arbitration between the two ports is fair. Each port has a ready handshake, and a stall request goes back to the core so slow memories can be modelled.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 0: extra wait states per access, range 0..15.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_ce_i` in 1: fetch request, held until `if_ready_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_inst_o` out 32: fetched word, valid while `if_ready_o`.
- `if_ready_o` out 1: one-cycle fetch completion pulse.
- `mem_ce_i` in 1: load/store request, held until `mem_ready_o`.
- `mem_we_i` in 1: 1 selects store, 0 selects load.
- `mem_addr_i` in 32: load/store byte address.
- `mem_sel_i` in 4: byte enables; `sel[3]` selects `data[31:24]` (big-endian lane order).
- `mem_data_i` in 32: store data.
- `mem_data_o` out 32: load data, valid while `mem_ready_o`.
- `mem_ready_o` out 1: one-cycle load/store completion pulse.
- `stall_req_o` out 1: asserted to the pipeline while any request is pending and not completing.

## Operation
Addressing:
- Word index is `addr[ADDR_WIDTH+1:2]`.
- `addr[1:0]` and the bits above the index are ignored, so addresses wrap modulo the depth.

State machine states:
- IDLE, BUSY (wait-state countdown) and RESP (completion cycle).

IDLE:
- If any `ce` is high, grant one port, latch its index, `we`, `sel` and data, load `cnt`=WAIT_CYCLES, and go to BUSY.

Arbitration:
- MEM wins by default.
- IF wins when both request and the previous grant went to MEM.
- A `last_grant` flag records the previous grant; it resets to IF.

BUSY:
- If the granted port's `ce` drops, abort: return to IDLE with no RAM write and no ready pulse.
- Else if `cnt`≠0, decrement `cnt`.
- Else (`cnt`=0), perform the access and go to RESP.
  - Store: write byte lanes whose `sel` bit is 1; other lanes are unchanged.
  - Load or fetch: register the full word into `mem_data_o` or `if_inst_o`.
- A store with `sel`=0 completes normally and writes nothing.

RESP:
- Assert the granted port's ready for exactly one cycle, then go to IDLE.
- The data output holds its value until the next completion on that port.

`stall_req_o`:
- Asserted when (`if_ce_i` or `mem_ce_i`) and no ready output is high.
- Combinational from state and inputs.

Reset:
- All outputs go to 0, state goes to IDLE, `cnt` goes to 0, `last_grant` goes to IF.
- RAM contents are not cleared.
- Reset during BUSY discards the access; because a write occurs only on the single RESP-entry edge, a store is either fully done or not done.

## Timing
Latency:
- A request sampled at edge E0 in IDLE gives ready high in the cycle after edge E0+WAIT_CYCLES+1.
- Request-to-ready latency is therefore WAIT_CYCLES+2 cycles; with WAIT_CYCLES=0 that is 2 cycles.

Throughput:
- One access per WAIT_CYCLES+3 cycles, because RESP returns to IDLE before the next grant.

Handshake rules:
- The requester must hold `addr`, `we`, `sel` and `data` stable from assertion until ready.
- Changes to these inputs while BUSY are ignored, because the values were latched at grant.
- Dropping `ce` before ready aborts the access.

Simultaneous events:
- A new request arriving during RESP is not granted until the following IDLE cycle.
- The non-granted port sees `stall_req_o` high and ready low for the whole transaction.

Ready behaviour:
- `if_ready_o` and `mem_ready_o` are never high together.

## Test plan
- Reset, WAIT_CYCLES=0: store 0xDEADBEEF with `sel`=1111 to 0x10, then load 0x10 → `mem_ready_o` 2 cycles after each request, `mem_data_o`=0xDEADBEEF, `stall_req_o` low only in the RESP cycle.
- Byte lanes: preload 0x11223344 at 0x20, store 0xAABBCCDD with `sel`=0100, then load → 0x11BB3344; store with `sel`=0000 → word unchanged.
- Wait states, WAIT_CYCLES=3: fetch 0x0 → `if_ready_o` exactly 5 cycles after request; `stall_req_o` high for the preceding 4 cycles.
- Arbitration: hold `if_ce_i` and `mem_ce_i` continuously from reset → grants alternate, MEM first then IF, and neither port is granted twice in a row.
- Wrap and abort, ADDR_WIDTH=4:
  - Store 0x5 to 0x40, then load 0x0 → 0x5.
  - Store 0x9 to 0x8 but drop `mem_ce_i` during BUSY → no ready pulse, word unchanged.
- Reset mid-access: assert `rst` during BUSY of a store to 0x30 → all outputs 0 immediately, the word at 0x30 keeps its old value, and the next request completes normally.
